// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet parser.
// Optional inter-byte timeout: define UART_PKT_TIMEOUT_EN.
package uart_pkg;

   typedef enum logic [1:0] {
      S_HUNT    = 2'd0,
      S_GET_LEN = 2'd1,
      S_PAYLOAD = 2'd2,
      S_GET_CHK = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_CHK     = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_outreg.sv
// One-entry valid/ready payload holding register.
// o_free tells the parser a new byte may land next cycle.
module uart_pkt_outreg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLKip,
   input  logic                  RSTni,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_last,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last,
   output logic                  o_free
);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_last;

   assign o_free  = !r_valid || i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;

   always_ff @(posedge CLKip or negedge RSTni) begin
      if (!RSTni) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_last  <= i_last;
      end else if (i_ready) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_pkt_parser.sv
// Frame parser: SOF, LEN, payload, XOR check, fed from a UART RX FIFO.
// Optional inter-byte timeout: define UART_PKT_TIMEOUT_EN.
module uart_pkt_parser
   import uart_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    MAX_LEN        = 64,
   parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = DATA_WIDTH'(SOF_DEFAULT),
   parameter int                    TIMEOUT_CYCLES = 100_000
) (
   input  logic                  CLKip,
   input  logic                  RSTni,
   input  logic                  EMPTYi,
   input  logic [DATA_WIDTH-1:0] DATAi,
   output logic                  RDo,
   output logic [DATA_WIDTH-1:0] PAY_DATAo,
   output logic                  PAY_VALIDo,
   input  logic                  PAY_READYi,
   output logic                  PAY_LASTo,
   output logic                  FRAME_OKo,
   output logic                  FRAME_ERRo,
   output logic [1:0]            ERR_CODEo
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_rd_pend;
   logic [DATA_WIDTH-1:0] r_cnt;
   logic [DATA_WIDTH-1:0] w_cnt_nxt;
   logic [DATA_WIDTH-1:0] r_xor;
   logic [DATA_WIDTH-1:0] w_xor_nxt;
   logic                  r_ok;
   logic                  w_ok_nxt;
   logic                  r_err;
   logic                  w_err_nxt;
   err_code_t             r_code;
   err_code_t             w_code_nxt;
   logic                  w_byte;
   logic                  w_load;
   logic                  w_last;
   logic                  w_slot_free;
   logic                  w_len_bad;

   // A byte is on DATAi exactly one cycle after its read strobe.
   assign w_byte    = r_rd_pend;
   assign RDo       = !EMPTYi && !r_rd_pend &&
                      ((r_state != S_PAYLOAD) || w_slot_free);
   assign w_len_bad = (DATAi == '0) ||
                      (DATAi > DATA_WIDTH'(MAX_LEN));

   assign FRAME_OKo  = r_ok;
   assign FRAME_ERRo = r_err;
   assign ERR_CODEo  = r_code;

`ifdef UART_PKT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;
   logic          w_to_fire;

   assign w_to_fire = (r_state != S_HUNT) && !w_byte &&
                      (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLKip or negedge RSTni) begin
      if (!RSTni) begin
         r_to_cnt <= '0;
      end else if ((r_state == S_HUNT) || w_byte) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_xor_nxt   = r_xor;
      w_ok_nxt    = 1'b0;
      w_err_nxt   = 1'b0;
      w_code_nxt  = r_code;
      w_load      = 1'b0;
      w_last      = 1'b0;
      unique case (r_state)
         S_HUNT: begin
            if (w_byte && (DATAi == SOF_BYTE)) begin
               w_state_nxt = S_GET_LEN;
            end
         end
         S_GET_LEN: begin
            if (w_byte) begin
               if (w_len_bad) begin
                  w_err_nxt   = 1'b1;
                  w_code_nxt  = ERR_LEN;
                  w_state_nxt = S_HUNT;
               end else begin
                  w_cnt_nxt   = DATAi;
                  w_xor_nxt   = DATAi;
                  w_state_nxt = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (w_byte) begin
               w_load    = 1'b1;
               w_xor_nxt = r_xor ^ DATAi;
               w_cnt_nxt = r_cnt - 1'b1;
               if (r_cnt == DATA_WIDTH'(1)) begin
                  w_last      = 1'b1;
                  w_state_nxt = S_GET_CHK;
               end
            end
         end
         S_GET_CHK: begin
            if (w_byte) begin
               if (DATAi == r_xor) begin
                  w_ok_nxt   = 1'b1;
                  w_code_nxt = ERR_NONE;
               end else begin
                  w_err_nxt  = 1'b1;
                  w_code_nxt = ERR_CHK;
               end
               w_state_nxt = S_HUNT;
            end
         end
      endcase
`ifdef UART_PKT_TIMEOUT_EN
      if (w_to_fire) begin
         w_err_nxt   = 1'b1;
         w_code_nxt  = ERR_TIMEOUT;
         w_state_nxt = S_HUNT;
      end
`endif
   end

   always_ff @(posedge CLKip or negedge RSTni) begin
      if (!RSTni) begin
         r_state   <= S_HUNT;
         r_rd_pend <= 1'b0;
         r_cnt     <= '0;
         r_xor     <= '0;
         r_ok      <= 1'b0;
         r_err     <= 1'b0;
         r_code    <= ERR_NONE;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_pend <= RDo;
         r_cnt     <= w_cnt_nxt;
         r_xor     <= w_xor_nxt;
         r_ok      <= w_ok_nxt;
         r_err     <= w_err_nxt;
         r_code    <= w_code_nxt;
      end
   end

   uart_pkt_outreg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_outreg (
      .CLKip   (CLKip),
      .RSTni   (RSTni),
      .i_load  (w_load),
      .i_data  (DATAi),
      .i_last  (w_last),
      .i_ready (PAY_READYi),
      .o_valid (PAY_VALIDo),
      .o_data  (PAY_DATAo),
      .o_last  (PAY_LASTo),
      .o_free  (w_slot_free)
   );

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Bench for uart_pkt_parser: FIFO model, frame-level reference model.
// Build with UART_PKT_TIMEOUT_EN to cover the timeout path.
module tb_uart_pkt_parser;

   typedef logic [7:0] bq_t[$];

   logic       CLKip = 1'b0;
   logic       RSTni = 1'b0;
   logic       EMPTYi = 1'b1;
   logic [7:0] DATAi = 8'h00;
   logic       PAY_READYi = 1'b0;
   logic       RDo;
   logic [7:0] PAY_DATAo;
   logic       PAY_VALIDo;
   logic       PAY_LASTo;
   logic       FRAME_OKo;
   logic       FRAME_ERRo;
   logic [1:0] ERR_CODEo;

   always #5 CLKip = ~CLKip;

   uart_pkt_parser #(
      .DATA_WIDTH     (8),
      .MAX_LEN        (64),
      .SOF_BYTE       (8'hA5),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .CLKip      (CLKip),
      .RSTni      (RSTni),
      .EMPTYi     (EMPTYi),
      .DATAi      (DATAi),
      .RDo        (RDo),
      .PAY_DATAo  (PAY_DATAo),
      .PAY_VALIDo (PAY_VALIDo),
      .PAY_READYi (PAY_READYi),
      .PAY_LASTo  (PAY_LASTo),
      .FRAME_OKo  (FRAME_OKo),
      .FRAME_ERRo (FRAME_ERRo),
      .ERR_CODEo  (ERR_CODEo)
   );

   bq_t        fifo;
   bq_t        gen_q;
   logic [8:0] got_pay[$];
   logic [8:0] exp_pay[$];
   int         got_ev[$];
   int         exp_ev[$];
   int         n_vec = 0;
   int         n_fail = 0;
   int         rd_empty_err = 0;
   int         dbl_rd_err = 0;
   int         stab_err = 0;
   logic       prev_rd = 1'b0;
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_last = 1'b0;

   // Upstream FIFO: a strobe pops one byte, visible the next cycle.
   always @(posedge CLKip) begin
      if (RDo) begin
         if (fifo.size() == 0) rd_empty_err++;
         else DATAi <= fifo.pop_front();
      end
      if (RDo && prev_rd) dbl_rd_err++;
      prev_rd <= RDo;
   end

   // Downstream monitor, sampled mid-cycle after READY is set.
   always begin
      @(negedge CLKip);
      #3;
      if (RSTni) begin
         if (prev_hold && !(PAY_VALIDo && PAY_DATAo == prev_data &&
                            PAY_LASTo == prev_last))
            stab_err++;
         if (PAY_VALIDo && PAY_READYi)
            got_pay.push_back({PAY_LASTo, PAY_DATAo});
         if (FRAME_OKo) got_ev.push_back(4 + int'(ERR_CODEo));
         if (FRAME_ERRo) got_ev.push_back(int'(ERR_CODEo));
         prev_hold = PAY_VALIDo && !PAY_READYi;
         prev_data = PAY_DATAo;
         prev_last = PAY_LASTo;
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: frame rules applied to the whole byte stream.
   // Events: 4 = good frame, 1 = bad LEN, 2 = checksum, 3 = timeout.
   function automatic void model(input bq_t s);
      int st;
      int len;
      int n;
      logic [7:0] x;
      exp_pay.delete();
      exp_ev.delete();
      st = 0; len = 0; n = 0; x = 8'h00;
      foreach (s[i]) begin
         case (st)
            0: if (s[i] == 8'hA5) st = 1;
            1: begin
               if (s[i] == 8'h00 || s[i] > 8'd64) begin
                  exp_ev.push_back(1);
                  st = 0;
               end else begin
                  len = int'(s[i]);
                  x = s[i];
                  n = 0;
                  st = 2;
               end
            end
            2: begin
               n++;
               x ^= s[i];
               exp_pay.push_back({(n == len), s[i]});
               if (n == len) st = 3;
            end
            default: begin
               exp_ev.push_back((s[i] == x) ? 4 : 2);
               st = 0;
            end
         endcase
      end
`ifdef UART_PKT_TIMEOUT_EN
      if (st != 0) exp_ev.push_back(3);
`endif
   endfunction

   task automatic add_frame();
      int nz;
      int r;
      int len;
      logic [7:0] b;
      logic [7:0] x;
      nz = $urandom_range(0, 2);
      repeat (nz) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h00;
         gen_q.push_back(b);
      end
      gen_q.push_back(8'hA5);
      r = $urandom_range(0, 9);
      if (r == 0) begin
         if ($urandom_range(0, 1) == 1) gen_q.push_back(8'h00);
         else gen_q.push_back(8'($urandom_range(65, 255)));
         return;
      end
      len = $urandom_range(1, 6);
      x = 8'(len);
      gen_q.push_back(8'(len));
      repeat (len) begin
         b = 8'($urandom);
         x ^= b;
         gen_q.push_back(b);
      end
      if (r == 1) x ^= 8'(1 << $urandom_range(0, 7));
      gen_q.push_back(x);
   endtask

   task automatic compare(input string tag);
      int last;
      chk({tag, ".npay"}, got_pay.size(), exp_pay.size());
      foreach (exp_pay[i])
         if (i < got_pay.size())
            chk($sformatf("%s.pay%0d", tag, i), got_pay[i], exp_pay[i]);
      chk({tag, ".nev"}, got_ev.size(), exp_ev.size());
      foreach (exp_ev[i])
         if (i < got_ev.size())
            chk($sformatf("%s.ev%0d", tag, i), got_ev[i], exp_ev[i]);
      if (exp_ev.size() > 0) begin
         last = exp_ev[exp_ev.size() - 1];
         chk({tag, ".code"}, ERR_CODEo, (last == 4) ? 0 : last);
      end
      chk({tag, ".rd_empty"}, rd_empty_err, 0);
      chk({tag, ".rd_dbl"}, dbl_rd_err, 0);
      chk({tag, ".stable"}, stab_err, 0);
      chk({tag, ".drained"}, PAY_VALIDo, 1'b0);
   endtask

   // mode 0: READY high; 1: random READY; 2: READY low for `hold`
   // cycles of valid data, starting with the first payload byte.
   task automatic run_stream(input string tag, input bq_t s,
                             input int mode, input int hold);
      int cyc;
      int tail;
      int seen;
      model(s);
      got_pay.delete();
      got_ev.delete();
      foreach (s[i]) fifo.push_back(s[i]);
      cyc = 0; tail = 0; seen = 0;
      while (tail < 80 && cyc < 4000) begin
         @(negedge CLKip);
         #2;
         cyc++;
         EMPTYi = (fifo.size() == 0);
         case (mode)
            0: PAY_READYi = 1'b1;
            1: PAY_READYi = 1'($urandom_range(0, 1));
            default: begin
               if (PAY_VALIDo) seen++;
               PAY_READYi = (seen > hold);
               if (PAY_VALIDo && seen == 10) begin
                  chk({tag, ".held"}, PAY_DATAo, 8'h01);
                  chk({tag, ".no_prefetch"}, fifo.size(), 2);
               end
            end
         endcase
         if (fifo.size() == 0 && !PAY_VALIDo) tail++;
         else tail = 0;
      end
      chk({tag, ".budget"}, (cyc < 4000), 1'b1);
      compare(tag);
   endtask

   initial begin
      bq_t s;
      #2;
      chk("rst.rd", RDo, 1'b0);
      chk("rst.valid", PAY_VALIDo, 1'b0);
      chk("rst.last", PAY_LASTo, 1'b0);
      chk("rst.data", PAY_DATAo, 8'h00);
      chk("rst.ok", FRAME_OKo, 1'b0);
      chk("rst.err", FRAME_ERRo, 1'b0);
      chk("rst.code", ERR_CODEo, 2'd0);
      repeat (3) @(negedge CLKip);
      RSTni = 1'b1;

      s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      run_stream("basic", s, 0, 0);
      s = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'h0F, 8'hA8};
      run_stream("noise", s, 0, 0);
      s = '{8'hA5, 8'h00, 8'hA5, 8'h41};
      run_stream("badlen", s, 0, 0);
      s = '{8'hA5, 8'h01, 8'h5A, 8'h00};
      run_stream("badchk", s, 0, 0);
      s = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01};
      run_stream("stall", s, 2, 20);

      got_ev.delete();
      PAY_READYi = 1'b0;
      s = '{8'hA5, 8'h03, 8'h11, 8'h22};
      foreach (s[i]) fifo.push_back(s[i]);
      repeat (12) begin
         @(negedge CLKip);
         #2;
         EMPTYi = (fifo.size() == 0);
      end
      chk("midrst.held", PAY_VALIDo, 1'b1);
      RSTni = 1'b0;
      fifo.delete();
      EMPTYi = 1'b1;
      #1;
      chk("midrst.valid", PAY_VALIDo, 1'b0);
      chk("midrst.rd", RDo, 1'b0);
      chk("midrst.code", ERR_CODEo, 2'd0);
      repeat (2) @(negedge CLKip);
      RSTni = 1'b1;
      repeat (2) @(negedge CLKip);
      chk("midrst.noev", got_ev.size(), 0);
      s = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
      run_stream("postrst", s, 0, 0);

`ifdef UART_PKT_TIMEOUT_EN
      s = '{8'hA5, 8'h02, 8'h01};
      run_stream("timeout", s, 0, 0);
`endif

      for (int k = 0; k < 6; k++) begin
         gen_q.delete();
         repeat (4) add_frame();
         run_stream($sformatf("rand%0d", k), gen_q, 1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
